// File: rtl/mx_xmit_if.sv
// mx_xmit_if: byte-offer handshake plus Manchester line outputs for mx_xmit.
// The master drives data/valid; the transmitter (slave) drives rdy, txd and txen.
interface mx_xmit_if;
   logic [7:0] data;
   logic       valid;
   logic       rdy;
   logic       txd;
   logic       txen;

   modport master (output data, valid, input rdy, txd, txen);
   modport slave  (input data, valid, output rdy, txd, txen);
endinterface

// File: rtl/mx_xmit.sv
// mx_xmit: Manchester framer (preamble, SFD 0xD0, LSB-first data, 2-bit EOF); txen starts one clk after accept.
// Define MX_XMIT_LONG_PREAMBLE_EN for a 32-bit preamble; rdy=0 while the holding register is full or in EOF.
module mx_xmit #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BIT_RATE = 50000
) (
   input  logic     clk,
   input  logic     rst,
   mx_xmit_if.slave bus
);
   localparam int HALF = CLK_FREQ / (2 * BIT_RATE);
   localparam int CW   = (HALF < 2) ? 1 : $clog2(HALF);
`ifdef MX_XMIT_LONG_PREAMBLE_EN
   localparam int PRE_BITS = 32;
`else
   localparam int PRE_BITS = 16;
`endif
   localparam int BW = $clog2(PRE_BITS);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
   localparam logic [BW-1:0] PRE_LAST  = BW'(PRE_BITS - 1);
   localparam logic [BW-1:0] BYTE_LAST = BW'(7);
   localparam logic [BW-1:0] EOF_LAST  = BW'(3);
   localparam logic [7:0]    SFD_BYTE  = 8'hD0;

   generate
      if (HALF < 2) begin : g_half_chk
         $error("mx_xmit: CLK_FREQ/(2*BIT_RATE) must be at least 2");
      end
   endgenerate

   typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, EOF} state_t;

   state_t        state_q;
   logic [CW-1:0] half_q;
   logic          sec_q;
   logic [BW-1:0] bit_q;
   logic [7:0]    hold_q;
   logic [7:0]    shift_q;
   logic          full_q;
   logic          txd_q;
   logic          txen_q;

   logic          accept;
   logic          half_end;
   logic          bit_end;
   logic [BW-1:0] bit_inc_d;
   logic [2:0]    sfd_idx_d;
   logic          cur_bit_d;

   assign bus.rdy   = !full_q && (state_q != EOF);
   assign bus.txd   = txd_q;
   assign bus.txen  = txen_q;
   assign accept    = bus.valid && bus.rdy;
   assign half_end  = (half_q == HALF_LAST);
   assign bit_end   = half_end && sec_q;
   assign bit_inc_d = bit_q + 1'b1;
   assign sfd_idx_d = bit_inc_d[2:0];

   always_comb begin
      cur_bit_d = 1'b1;
      case (state_q)
         PREAMBLE: cur_bit_d = ~bit_q[0];
         SFD:      cur_bit_d = SFD_BYTE[bit_q[2:0]];
         DATA:     cur_bit_d = shift_q[0];
         default:  cur_bit_d = 1'b1;
      endcase
   end

   // txd_q is loaded with the value of the half-bit that begins on this edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         half_q  <= '0;
         sec_q   <= 1'b0;
         bit_q   <= '0;
         hold_q  <= '0;
         shift_q <= '0;
         full_q  <= 1'b0;
         txd_q   <= 1'b1;
         txen_q  <= 1'b0;
      end else begin
         if (accept) begin
            hold_q <= bus.data;
            full_q <= 1'b1;
         end
         if (state_q != IDLE) begin
            half_q <= half_end ? '0 : half_q + 1'b1;
         end
         case (state_q)
            IDLE: begin
               txd_q  <= 1'b1;
               txen_q <= 1'b0;
               if (full_q) begin
                  state_q <= PREAMBLE;
                  sec_q   <= 1'b0;
                  bit_q   <= '0;
                  txen_q  <= 1'b1;
                  txd_q   <= 1'b1;
               end
            end
            PREAMBLE, SFD, DATA: begin
               if (half_end && !sec_q) begin
                  sec_q <= 1'b1;
                  txd_q <= ~cur_bit_d;
               end else if (bit_end) begin
                  sec_q <= 1'b0;
                  bit_q <= bit_inc_d;
                  case (state_q)
                     PREAMBLE: begin
                        if (bit_q == PRE_LAST) begin
                           state_q <= SFD;
                           bit_q   <= '0;
                           txd_q   <= SFD_BYTE[0];
                        end else begin
                           txd_q <= bit_q[0];
                        end
                     end
                     SFD: begin
                        if (bit_q == BYTE_LAST) begin
                           state_q <= DATA;
                           bit_q   <= '0;
                           shift_q <= hold_q;
                           full_q  <= 1'b0;
                           txd_q   <= hold_q[0];
                        end else begin
                           txd_q <= SFD_BYTE[sfd_idx_d];
                        end
                     end
                     default: begin
                        if (bit_q == BYTE_LAST) begin
                           bit_q <= '0;
                           // A byte offered exactly on the boundary bypasses the holding register.
                           if (full_q) begin
                              shift_q <= hold_q;
                              full_q  <= 1'b0;
                              txd_q   <= hold_q[0];
                           end else if (accept) begin
                              shift_q <= bus.data;
                              full_q  <= 1'b0;
                              txd_q   <= bus.data[0];
                           end else begin
                              state_q <= EOF;
                              txd_q   <= 1'b1;
                           end
                        end else begin
                           shift_q <= {1'b0, shift_q[7:1]};
                           txd_q   <= shift_q[1];
                        end
                     end
                  endcase
               end
            end
            EOF: begin
               txd_q <= 1'b1;
               if (half_end) begin
                  if (bit_q == EOF_LAST) begin
                     state_q <= IDLE;
                     bit_q   <= '0;
                     txen_q  <= 1'b0;
                  end else begin
                     bit_q <= bit_inc_d;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mx_xmit.sv
// tb_mx_xmit: directed frames into mx_xmit; a loopback Manchester decoder pops expected bytes and frame lengths.
module tb_mx_xmit;
   localparam int H   = 4;
   localparam int BIT = 2 * H;
`ifdef MX_XMIT_LONG_PREAMBLE_EN
   localparam int PRE = 32;
`else
   localparam int PRE = 16;
`endif
   localparam int DATA_START = (PRE + 8) * BIT;
   localparam int DATA_END   = (PRE + 16) * BIT;

   logic clk;
   logic rst;
   mx_xmit_if bus ();

   mx_xmit #(.CLK_FREQ(400), .BIT_RATE(50)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;
   int acc    = 0;
   int sent   = 0;
   logic [7:0] exp_q[$];
   int         len_q[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion before 2000000");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int frame_len(input int nbytes);
      return (PRE + 8 + 8 * nbytes) * BIT + 4 * H;
   endfunction

   // Loopback decoder: samples the middle of every half-bit while txen is high.
   int         cyc, nb, bits, merr, eofh;
   logic       act, in_eof, first;
   logic [7:0] sh;

   task automatic byte_done(input logic [7:0] b);
      if (nb < PRE / 8) chk("preamble_byte", b, 8'h55);
      else if (nb == PRE / 8) chk("sfd_byte", b, 8'hD0);
      else if (exp_q.size() == 0) chk("unexpected_byte", 1, 0);
      else begin
         chk("data_byte", b, exp_q.pop_front());
         sent++;
      end
      nb++;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         act = 1'b0;
      end else if (bus.txen === 1'b1) begin
         if (!act) begin
            act = 1'b1; cyc = 0; nb = 0; bits = 0; merr = 0; eofh = 0; in_eof = 1'b0; sh = '0;
         end
         if (cyc % H == H / 2) begin
            if (in_eof) begin
               if (bus.txd === 1'b1) eofh++;
               else merr++;
            end else if ((cyc / H) % 2 == 0) begin
               first = bus.txd;
            end else if (first === 1'b1 && bus.txd === 1'b1 && bits == 0 && nb >= PRE / 8 + 2) begin
               in_eof = 1'b1;
               eofh   = 2;
            end else begin
               if (first === bus.txd) merr++;
               sh = {first, sh[7:1]};
               bits++;
               if (bits == 8) begin
                  bits = 0;
                  byte_done(sh);
               end
            end
         end
         cyc++;
      end else if (act) begin
         act = 1'b0;
         if (len_q.size() == 0) chk("unexpected_frame", 1, 0);
         else chk("frame_len", cyc, len_q.pop_front());
         chk("eof_halves", eofh, 4);
         chk("manchester_errs", merr, 0);
      end
   end

   task automatic offer(input logic [7:0] b);
      int n;
      n = 0;
      while (bus.rdy !== 1'b1 && n < 5000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("offer_rdy_timeout", (n < 5000) ? 1 : 0, 1);
      bus.valid = 1'b1;
      bus.data  = b;
      exp_q.push_back(b);
      acc++;
      @(posedge clk); #1;
      bus.valid = 1'b0;
      bus.data  = ~b;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while ((len_q.size() != 0 || bus.txen !== 1'b0) && n < 5000) begin
         @(posedge clk); #1;
         n++;
      end
      chk({name, "_timeout"}, (n < 5000) ? 1 : 0, 1);
      repeat (2) @(posedge clk);
      #1;
      chk({name, "_bytes_left"}, exp_q.size(), 0);
   endtask

   initial begin
      logic [7:0] v;
      int n, k;
      bus.valid = 1'b0;
      bus.data  = 8'h00;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_txd", bus.txd, 1);
      chk("reset_txen", bus.txen, 0);
      chk("reset_rdy", bus.rdy, 1);
      rst = 1'b0;
      @(posedge clk); #1;

      // Single byte
      len_q.push_back(frame_len(1));
      offer(8'hA5);
      chk("rdy_after_accept", bus.rdy, 0);
      chk("txen_before_start", bus.txen, 0);
      @(posedge clk); #1;
      chk("txen_start", bus.txen, 1);
      chk("txd_first_half", bus.txd, 1);
      wait_done("single");
      chk("idle_txd", bus.txd, 1);
      chk("idle_rdy", bus.rdy, 1);

      // Back-to-back bytes form one frame
      len_q.push_back(frame_len(3));
      offer(8'h00);
      offer(8'hFF);
      offer(8'h3C);
      wait_done("b2b");

      // Byte offered exactly on the byte boundary continues the frame
      len_q.push_back(frame_len(2));
      offer(8'h81);
      @(posedge clk);
      repeat (DATA_END - 1) @(posedge clk);
      #1;
      chk("rdy_at_boundary", bus.rdy, 1);
      bus.valid = 1'b1;
      bus.data  = 8'h4E;
      exp_q.push_back(8'h4E);
      @(posedge clk); #1;
      bus.valid = 1'b0;
      chk("txen_after_boundary", bus.txen, 1);
      wait_done("boundary");

      // Late byte: first frame ends, EOF ignores valid, second frame restarts
      len_q.push_back(frame_len(1));
      len_q.push_back(frame_len(1));
      offer(8'h33);
      @(posedge clk);
      repeat (DATA_END) @(posedge clk);
      #1;
      chk("rdy_in_eof", bus.rdy, 0);
      chk("txd_in_eof", bus.txd, 1);
      bus.valid = 1'b1;
      bus.data  = 8'hEE;
      offer(8'hC7);
      wait_done("late");

      // Backpressure with data changing every cycle
      acc = 0;
      sent = 0;
      len_q.push_back(frame_len(4));
      v = 8'h11;
      n = 0;
      k = 0;
      while (n < 4 && k < 3000) begin
         bus.valid = 1'b1;
         bus.data  = v;
         if (bus.rdy === 1'b1) begin
            exp_q.push_back(v);
            acc++;
            n++;
         end
         @(posedge clk); #1;
         v = v + 8'h07;
         k++;
      end
      bus.valid = 1'b0;
      wait_done("backpressure");
      chk("bp_accepted_vs_sent", sent, acc);
      chk("bp_accepted", acc, 4);

      // Reset during the 4th data bit aborts at once
      offer(8'h96);
      @(posedge clk);
      repeat (DATA_START + 3 * BIT + 2) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("abort_txd", bus.txd, 1);
      chk("abort_txen", bus.txen, 0);
      chk("abort_rdy", bus.rdy, 1);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      len_q.push_back(frame_len(1));
      offer(8'h5A);
      wait_done("after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mx_xmit.md
MX_XMIT -- requirements
Module: mx_xmit

Interface
REQ-001 The module SHALL have parameter CLK_FREQ, default 100_000_000, meaning the clk frequency in Hz.
REQ-002 The module SHALL have parameter BIT_RATE, default 50000, meaning Manchester bits per second.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL be clocked on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The module SHALL have port data, input, 8 bits: the byte to send, sampled when valid && rdy.
REQ-006 The module SHALL have port valid, input, 1 bit: the byte-offer strobe.
REQ-007 The module SHALL have port rdy, output, 1 bit: high when the holding register can accept a byte.
REQ-008 The module SHALL have port txd, output, 1 bit: the registered Manchester line output, idle high.
REQ-009 The module SHALL have port txen, output, 1 bit: high for the whole frame, from the first preamble half-bit to the end of EOF.

Function
REQ-010 HALF SHALL equal CLK_FREQ/(2*BIT_RATE) clocks (1000 at defaults), and the design SHALL reject HALF<2 at elaboration.
REQ-011 Bit encoding SHALL be: '1' = txd high for HALF clocks then low for HALF; '0' = low for HALF then high for HALF.
REQ-012 All bytes SHALL be sent LSB first.
REQ-013 The FSM SHALL have states IDLE, PREAMBLE, SFD, DATA and EOF.
REQ-014 A frame SHALL be: a preamble of 16 bits alternating 1,0 (0x55, 0x55); then SFD byte 0xD0 (line order 0,0,0,0,1,0,1,1); then data bytes; then EOF.
REQ-015 In IDLE, an accepted byte (valid && rdy at edge N) SHALL load the holding register and move to PREAMBLE, with txen=1 and the first half-bit driven starting at edge N+1.
REQ-016 PREAMBLE SHALL go to SFD after 16 bits, and SFD SHALL go to DATA after 8 bits.
REQ-017 On entry to each data byte, the holding register SHALL move to the shift register and rdy SHALL rise.
REQ-018 At the end of the final half-bit of each byte: if the holding register is full, the FSM SHALL stay in DATA with no gap; if it is empty, the FSM SHALL go to EOF.
REQ-019 In EOF, txd SHALL be held at 1 for 2 bit periods (4*HALF clocks) with txen=1 and rdy=0; the FSM SHALL then return to IDLE with txen=0 and rdy=1.
REQ-020 rdy SHALL be 1 iff the holding register is empty and the state is not EOF; valid while rdy=0 SHALL be ignored and data SHALL NOT be sampled.
REQ-021 If valid && rdy occurs on the same edge as a byte boundary, the new byte SHALL be accepted and SHALL be sent as the next byte, without ending the frame.
REQ-022 The half-bit counter SHALL be ceil(log2(HALF)) bits wide and SHALL wrap from HALF-1 to 0; the bit counter SHALL be 3 bits, or 4 bits for the preamble.
REQ-023 txd SHALL change only on half-bit boundaries, with no glitches and registered output.

Reset
REQ-024 While rst=1, outputs SHALL be: txd=1, txen=0, rdy=1; state=IDLE; counters and holding/shift registers cleared.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously) with no EOF, and the next frame after release SHALL start from a full preamble.

Configuration
REQ-026 With macro MX_XMIT_LONG_PREAMBLE_EN defined, the preamble SHALL be 32 bits (0x55 x4); without it, the preamble SHALL be 16 bits. All other behaviour SHALL be identical.

Verification
REQ-027 Single byte: rst pulse, then valid=1 with data=0xA5 for one clk -> txen rises next edge; line carries 16 preamble bits, 0xD0, 0xA5 LSB-first; then txd=1 for 4000 clks; txen falls; total txen time = 32*2000+4000 clks.
REQ-028 Back-to-back: offer 0x00, 0xFF, 0x3C, each on the first cycle rdy is high -> one continuous frame carrying 3 data bytes, no idle gap, a single EOF; a loopback receiver reports those 3 bytes with no error.
REQ-029 Late byte: offer the second byte 1 clk after the first byte's last half-bit ends -> the first frame ends with EOF; the second byte starts a new frame with a full preamble.
REQ-030 Backpressure: hold valid=1 with changing data while rdy=0 -> only the values present on rdy=1 edges are transmitted; a count of accepted bytes equals the count of bytes sent.
REQ-031 Reset mid-data: assert rst during the 4th data bit -> txd=1 and txen=0 within the same time step; rdy=1; the next frame is correct.
REQ-032 With MX_XMIT_LONG_PREAMBLE_EN defined, repeat REQ-027 -> 32 preamble bits; total txen time = 48*2000+4000 clks.
